// File: rtl/scic_io_port_if.sv
// ---------------------------------------------------------------------------
// scic_io_port_if
// Register-access bus between a host and scic_io_port.
//   io_addr  : register select (0 SWITCH, 1 LED, 2 STATUS, 3 COUNT)
//   io_rd    : one-cycle read strobe
//   io_wr    : one-cycle write strobe
//   io_wdata : write data
//   io_rdata : read data, valid while io_ready is high, zero otherwise
//   io_ready : one-cycle completion pulse, the cycle after a strobe
// ---------------------------------------------------------------------------
interface scic_io_port_if;
    logic [1:0]  io_addr;
    logic        io_rd;
    logic        io_wr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_ready;

    modport master (
        output io_addr,
        output io_rd,
        output io_wr,
        output io_wdata,
        input  io_rdata,
        input  io_ready
    );

    modport slave (
        input  io_addr,
        input  io_rd,
        input  io_wr,
        input  io_wdata,
        output io_rdata,
        output io_ready
    );
endinterface

// File: rtl/scic_io_port.sv
// ---------------------------------------------------------------------------
// scic_io_port
// Debounced switch inputs and registered LED outputs behind a small
// four-register bus, with a sticky change flag, a change counter and a
// level interrupt.
//   clock    : single clock, all state on the rising edge
//   reset    : asynchronous, active-high reset
//   switches : raw asynchronous switch levels
//   LEDs     : registered LED drive
//   irq      : level interrupt, CHANGED & IRQ_EN
//   io       : register bus (slave side), see scic_io_port_if
// Register map:
//   0 SWITCH : debounced levels, read only
//   1 LED    : LED drive, R/W
//   2 STATUS : bit0 CHANGED (sticky, write 1 clears), bit1 IRQ_EN (R/W)
//   3 COUNT  : 16-bit change counter, R/W, wraps
// ---------------------------------------------------------------------------
module scic_io_port #(
    parameter int SW_WIDTH        = 4,
    parameter int LED_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [SW_WIDTH-1:0]  switches,
    output logic [LED_WIDTH-1:0] LEDs,
    output logic                 irq,
    scic_io_port_if.slave        io
);

    // The counter only ever holds 0..DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_SWITCH = 2'd0;
    localparam logic [1:0] ADDR_LED    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    logic [SW_WIDTH-1:0]          sync1_r;
    logic [SW_WIDTH-1:0]          sync2_r;
    logic [SW_WIDTH-1:0]          stable_r;
    logic [SW_WIDTH-1:0][CW-1:0]  cnt_r;
    logic [LED_WIDTH-1:0]         leds_r;
    logic                         changed_r;
    logic                         irq_en_r;
    logic [15:0]                  count_r;
    logic [31:0]                  rdata_r;
    logic                         ready_r;
    logic                         irq_r;

    logic [SW_WIDTH-1:0]          stable_nxt_s;
    logic [SW_WIDTH-1:0][CW-1:0]  cnt_nxt_s;
    logic                         change_s;
    logic                         strobe_s;
    logic                         wr_led_s;
    logic                         wr_status_s;
    logic                         wr_count_s;
    logic [31:0]                  read_val_s;
    logic [LED_WIDTH-1:0]         leds_nxt_s;
    logic                         changed_nxt_s;
    logic                         irq_en_nxt_s;
    logic [15:0]                  count_nxt_s;

    // Per-bit debounce: the Nth consecutive differing sample adopts the new level.
    always_comb begin
        stable_nxt_s = stable_r;
        cnt_nxt_s    = cnt_r;
        for (int i = 0; i < SW_WIDTH; i++) begin
            if (sync2_r[i] == stable_r[i]) begin
                cnt_nxt_s[i] = {CW{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                stable_nxt_s[i] = sync2_r[i];
                cnt_nxt_s[i]    = {CW{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end
        end
    end

    assign change_s    = (stable_nxt_s != stable_r);
    assign strobe_s    = io.io_rd | io.io_wr;
    assign wr_led_s    = io.io_wr && (io.io_addr == ADDR_LED);
    assign wr_status_s = io.io_wr && (io.io_addr == ADDR_STATUS);
    assign wr_count_s  = io.io_wr && (io.io_addr == ADDR_COUNT);

    // Read mux uses current register values, so a combined read+write returns pre-write data.
    always_comb begin
        read_val_s = 32'd0;
        case (io.io_addr)
            ADDR_SWITCH: read_val_s = {{(32-SW_WIDTH){1'b0}}, stable_r};
            ADDR_LED:    read_val_s = {{(32-LED_WIDTH){1'b0}}, leds_r};
            ADDR_STATUS: read_val_s = {30'd0, irq_en_r, changed_r};
            ADDR_COUNT:  read_val_s = {16'd0, count_r};
            default:     read_val_s = 32'd0;
        endcase
    end

    // Register-file next state; a new stable change beats a CHANGED clear,
    // while a COUNT write beats the increment.
    always_comb begin
        leds_nxt_s    = leds_r;
        changed_nxt_s = changed_r;
        irq_en_nxt_s  = irq_en_r;
        count_nxt_s   = count_r;
        if (wr_led_s) begin
            leds_nxt_s = io.io_wdata[LED_WIDTH-1:0];
        end else begin
            leds_nxt_s = leds_r;
        end
        if (change_s) begin
            changed_nxt_s = 1'b1;
        end else if (wr_status_s && io.io_wdata[0]) begin
            changed_nxt_s = 1'b0;
        end else begin
            changed_nxt_s = changed_r;
        end
        if (wr_status_s) begin
            irq_en_nxt_s = io.io_wdata[1];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
        if (wr_count_s) begin
            count_nxt_s = io.io_wdata[15:0];
        end else if (change_s) begin
            count_nxt_s = count_r + 16'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Synchroniser, debounce state and stable register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r  <= {SW_WIDTH{1'b0}};
            sync2_r  <= {SW_WIDTH{1'b0}};
            stable_r <= {SW_WIDTH{1'b0}};
            cnt_r    <= {(SW_WIDTH*CW){1'b0}};
        end else begin
            sync1_r  <= switches;
            sync2_r  <= sync1_r;
            stable_r <= stable_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    // Software-visible registers; irq is formed from the next flag values so it
    // tracks CHANGED & IRQ_EN with no additional cycle of delay.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leds_r    <= {LED_WIDTH{1'b0}};
            changed_r <= 1'b0;
            irq_en_r  <= 1'b0;
            count_r   <= 16'd0;
            irq_r     <= 1'b0;
        end else begin
            leds_r    <= leds_nxt_s;
            changed_r <= changed_nxt_s;
            irq_en_r  <= irq_en_nxt_s;
            count_r   <= count_nxt_s;
            irq_r     <= changed_nxt_s & irq_en_nxt_s;
        end
    end

    // Bus response: one-cycle ready with data, zero data otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_r <= 1'b0;
            rdata_r <= 32'd0;
        end else if (strobe_s) begin
            ready_r <= 1'b1;
            rdata_r <= read_val_s;
        end else begin
            ready_r <= 1'b0;
            rdata_r <= 32'd0;
        end
    end

    assign LEDs        = leds_r;
    assign irq         = irq_r;
    assign io.io_ready = ready_r;
    assign io.io_rdata = rdata_r;

endmodule

// File: tb/tb_scic_io_port.sv
// ---------------------------------------------------------------------------
// tb_scic_io_port
// Directed test of scic_io_port with default parameters (4 switches,
// 4 LEDs, DEBOUNCE_CYCLES=4). Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_scic_io_port;

    logic        clock;
    logic        reset;
    logic [3:0]  switches;
    logic [3:0]  leds;
    logic        irq;
    logic [31:0] rd_val;

    int checks_cnt = 0;
    int errors_cnt = 0;

    scic_io_port_if bus_if ();

    scic_io_port #(
        .SW_WIDTH       (4),
        .LED_WIDTH      (4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .switches(switches),
        .LEDs    (leds),
        .irq     (irq),
        .io      (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Strobe presented from the next falling edge, sampled on the following
    // rising edge; ready/data checked 1 unit after that edge.
    task automatic bus(input logic [1:0] a, input logic r, input logic w,
                       input logic [31:0] d, output logic [31:0] q);
        @(negedge clock);
        bus_if.io_addr  = a;
        bus_if.io_rd    = r;
        bus_if.io_wr    = w;
        bus_if.io_wdata = d;
        @(posedge clock);
        #1;
        bus_if.io_rd = 1'b0;
        bus_if.io_wr = 1'b0;
        check_eq("ready_pulse", {31'd0, bus_if.io_ready}, 32'd1);
        q = bus_if.io_rdata;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] q;
        bus(a, 1'b1, 1'b0, 32'd0, q);
        check_eq(tag, q, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        bus(a, 1'b0, 1'b1, d, q);
    endtask

    initial begin
        reset           = 1'b1;
        switches        = 4'b0000;
        bus_if.io_addr  = 2'd0;
        bus_if.io_rd    = 1'b0;
        bus_if.io_wr    = 1'b0;
        bus_if.io_wdata = 32'd0;
        tick(2);

        // Reset state
        check_eq("rst_leds",  {28'd0, leds}, 32'd0);
        check_eq("rst_irq",   {31'd0, irq}, 32'd0);
        check_eq("rst_ready", {31'd0, bus_if.io_ready}, 32'd0);
        check_eq("rst_rdata", bus_if.io_rdata, 32'd0);
        reset = 1'b0;
        tick(1);
        rd_check("rst_status", 2'd2, 32'd0);
        rd_check("rst_count",  2'd3, 32'd0);

        // Short glitches never reach the stable register
        switches = 4'b0001;
        tick(2);
        switches = 4'b0000;
        tick(1);
        switches = 4'b0100;
        tick(3);
        switches = 4'b0000;
        tick(10);
        rd_check("glitch_switch", 2'd0, 32'd0);
        rd_check("glitch_count",  2'd3, 32'd0);
        check_eq("glitch_irq", {31'd0, irq}, 32'd0);

        // Held level is accepted
        switches = 4'b0101;
        tick(10);
        rd_check("held_switch", 2'd0, 32'h0000_0005);
        rd_check("held_status", 2'd2, 32'h0000_0001);
        rd_check("held_count",  2'd3, 32'h0000_0001);
        check_eq("held_irq_dis", {31'd0, irq}, 32'd0);

        // LED write/read with ready timing
        wr(2'd1, 32'hFFFF_FFFA);
        check_eq("led_drive", {28'd0, leds}, 32'h0000_000A);
        rd_check("led_read", 2'd1, 32'h0000_000A);
        tick(1);
        check_eq("idle_ready", {31'd0, bus_if.io_ready}, 32'd0);
        check_eq("idle_rdata", bus_if.io_rdata, 32'd0);

        // Clear CHANGED, enable interrupt
        wr(2'd2, 32'h0000_0003);
        check_eq("clr_irq", {31'd0, irq}, 32'd0);
        rd_check("clr_status", 2'd2, 32'h0000_0002);

        // Exact acceptance edge: DEBOUNCE_CYCLES+2 = 6 edges after the change
        switches = 4'b0100;
        tick(5);
        check_eq("edge5_irq", {31'd0, irq}, 32'd0);
        tick(1);
        check_eq("edge6_irq", {31'd0, irq}, 32'd1);
        rd_check("irq_count", 2'd3, 32'h0000_0002);

        // CHANGED clear on the same edge as a new change: set wins
        switches = 4'b0000;
        tick(5);
        wr(2'd2, 32'h0000_0003);
        check_eq("same_edge_irq", {31'd0, irq}, 32'd1);
        rd_check("same_edge_status", 2'd2, 32'h0000_0003);
        rd_check("same_edge_count",  2'd3, 32'h0000_0003);
        wr(2'd2, 32'h0000_0003);
        check_eq("plain_clr_irq", {31'd0, irq}, 32'd0);

        // COUNT write on the same edge as a change: written value wins
        switches = 4'b0001;
        tick(5);
        wr(2'd3, 32'h0000_1234);
        rd_check("cnt_wr_wins", 2'd3, 32'h0000_1234);

        // COUNT wrap
        wr(2'd3, 32'h0000_FFFF);
        switches = 4'b0000;
        tick(10);
        rd_check("cnt_wrap", 2'd3, 32'h0000_0000);

        // Combined read+write returns the pre-write value
        bus(2'd1, 1'b1, 1'b1, 32'h0000_0005, rd_val);
        check_eq("rdwr_old", rd_val, 32'h0000_000A);
        check_eq("rdwr_leds", {28'd0, leds}, 32'h0000_0005);

        // Back-to-back reads every cycle
        @(negedge clock);
        bus_if.io_rd   = 1'b1;
        bus_if.io_addr = 2'd0;
        @(posedge clock);
        #1;
        check_eq("b2b_ready0", {31'd0, bus_if.io_ready}, 32'd1);
        check_eq("b2b_data0", bus_if.io_rdata, 32'h0000_0000);
        bus_if.io_addr = 2'd1;
        @(posedge clock);
        #1;
        check_eq("b2b_ready1", {31'd0, bus_if.io_ready}, 32'd1);
        check_eq("b2b_data1", bus_if.io_rdata, 32'h0000_0005);
        bus_if.io_addr = 2'd2;
        @(posedge clock);
        #1;
        bus_if.io_rd = 1'b0;
        check_eq("b2b_ready2", {31'd0, bus_if.io_ready}, 32'd1);
        check_eq("b2b_data2", bus_if.io_rdata, 32'h0000_0003);
        tick(1);
        check_eq("b2b_end", {31'd0, bus_if.io_ready}, 32'd0);

        // Reset between write strobe and ready
        switches = 4'b0011;
        @(negedge clock);
        bus_if.io_addr  = 2'd1;
        bus_if.io_wr    = 1'b1;
        bus_if.io_wdata = 32'h0000_000F;
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        bus_if.io_wr = 1'b0;
        check_eq("mid_rst_ready", {31'd0, bus_if.io_ready}, 32'd0);
        check_eq("mid_rst_leds",  {28'd0, leds}, 32'd0);
        check_eq("mid_rst_irq",   {31'd0, irq}, 32'd0);
        reset = 1'b0;
        tick(1);
        check_eq("post_rst_ready", {31'd0, bus_if.io_ready}, 32'd0);
        rd_check("post_rst_led", 2'd1, 32'd0);
        rd_check("post_rst_status", 2'd2, 32'd0);

        // Switches already high across reset release count as one change
        tick(10);
        rd_check("rel_switch", 2'd0, 32'h0000_0003);
        rd_check("rel_count",  2'd3, 32'h0000_0001);
        rd_check("rel_status", 2'd2, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
